fetch_pc_sequencer: RTL and testbench

- Instruction-fetch sequencer directly upstream of the 32-bit program-counter register.
- Drives that register's write-data and write-enable, and reads its current value back.
- Issues one instruction-memory request at a time and handles the response.
- Presents fetched instructions to decode with a valid/ready handshake. Branch/jump redirects preempt fetch.

---
 rtl/fetch_pc_sequencer.sv | 80 ++++++++
 tb/tb_fetch_pc_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: single-outstanding instruction fetch FSM that drives the PC register
// and hands fetched words to decode; branch/jump redirects preempt fetch.
module fetch_pc_sequencer #(
   parameter int XLEN    = 32,
   parameter int PC_STEP = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_q,
   output logic [XLEN-1:0] pc_wd,
   output logic            pc_we,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_out,
   output logic [XLEN-1:0] inst_pc,
   output logic            busy
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   state_t          r_state;
   state_t          w_next;
   logic            r_kill;
   logic            w_kill_next;
   logic            w_capture;
   logic            w_redir;
   logic [XLEN-1:0] r_inst_out;
   logic [XLEN-1:0] r_inst_pc;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_kill     <= 1'b0;
         r_inst_out <= '0;
         r_inst_pc  <= '0;
      end else begin
         r_state <= w_next;
         r_kill  <= w_kill_next;
         if (w_capture) begin
            r_inst_out <= imem_rdata;
            r_inst_pc  <= pc_q;
         end
      end
   end
   // a response that meets a redirect or a pending kill is dropped and refetched
   always_comb begin
      w_next      = r_state;
      w_kill_next = r_kill;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_REQ;
         S_REQ:  w_next = (!redirect_valid && imem_gnt) ? S_WAIT : S_REQ;
         S_WAIT: begin
            if (imem_rvalid) begin
               w_capture   = !redirect_valid && !r_kill;
               w_next      = w_capture ? S_HOLD : S_REQ;
               w_kill_next = 1'b0;
            end else if (redirect_valid) begin
               w_kill_next = 1'b1;
            end
         end
         default: w_next = (redirect_valid || inst_ready) ? S_REQ : S_HOLD;
      endcase
   end
   assign w_redir    = redirect_valid && (r_state != S_IDLE);
   assign pc_we      = w_redir || w_capture;
   assign pc_wd      = w_redir ? (redirect_target & ALIGN_MASK) :
                       w_capture ? pc_q + XLEN'(PC_STEP) : pc_q;
   assign imem_req   = (r_state == S_REQ) && !redirect_valid;
   assign imem_addr  = pc_q & ALIGN_MASK;
   assign busy       = (r_state == S_WAIT);
   assign inst_valid = (r_state == S_HOLD);
   assign inst_out   = r_inst_out;
   assign inst_pc    = r_inst_pc;
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// tb_fetch_pc_sequencer: directed fetch scenarios; handed-off instructions are checked
// against a scoreboard queue by a separate monitor.
module tb_fetch_pc_sequencer;
   logic        clock = 0;
   logic        reset = 1;
   logic [31:0] pc_q;
   logic [31:0] pc_wd;
   logic        pc_we;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 0;
   logic        imem_rvalid = 0;
   logic [31:0] imem_rdata = 0;
   logic        redirect_valid = 0;
   logic [31:0] redirect_target = 0;
   logic        inst_valid;
   logic        inst_ready = 1;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        busy;
   int          n_pass = 0;
   int          n_total = 0;
   logic [63:0] exp_q[$];

   fetch_pc_sequencer dut (
      .clock(clock), .reset(reset), .pc_q(pc_q), .pc_wd(pc_wd), .pc_we(pc_we),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
      .inst_pc(inst_pc), .busy(busy)
   );

   always #5 clock = ~clock;

   // the PC register this block sits in front of
   always_ff @(posedge clock or posedge reset)
      if (reset) pc_q <= '0;
      else if (pc_we) pc_q <= pc_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic cyc(input logic gnt, input logic rv, input logic [31:0] rd,
                      input logic rdv, input logic [31:0] tgt, input logic rdy);
      @(negedge clock);
      imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
      redirect_valid = rdv; redirect_target = tgt; inst_ready = rdy;
      #1;
   endtask

   // monitor: every hand-off must match the oldest expected instruction
   always @(negedge clock) begin
      #4;
      if (!reset && inst_valid && inst_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL handoff: unexpected inst %h pc %h at %0t", inst_out, inst_pc, $time);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("handoff_inst", inst_out, e[63:32]);
            chk("handoff_pc", inst_pc, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clock);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_we", pc_we, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst_out, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_busy", busy, 0);
      // IDLE cycle: redirect ignored
      @(negedge clock);
      reset = 0; redirect_valid = 1; redirect_target = 32'h80;
      #1;
      chk("idle_req", imem_req, 0);
      chk("idle_redir_we", pc_we, 0);
      // basic fetch
      cyc(1, 0, 0, 0, 0, 1);
      chk("b_req", imem_req, 1); chk("b_addr", imem_addr, 0); chk("b_busy", busy, 0);
      cyc(0, 1, 32'h00500093, 0, 0, 1);
      exp_q.push_back({32'h00500093, 32'h0});
      chk("b_wait_busy", busy, 1); chk("b_wait_req", imem_req, 0);
      chk("b_we", pc_we, 1); chk("b_wd", pc_wd, 32'h4);
      cyc(0, 0, 0, 0, 0, 1);
      chk("b_valid", inst_valid, 1); chk("b_inst", inst_out, 32'h00500093); chk("b_ipc", inst_pc, 0);
      // backpressure
      cyc(1, 0, 0, 0, 0, 0);
      chk("bp_req", imem_req, 1); chk("bp_addr", imem_addr, 32'h4);
      cyc(0, 1, 32'h11111111, 0, 0, 0);
      exp_q.push_back({32'h11111111, 32'h4});
      chk("bp_wd", pc_wd, 32'h8);
      repeat (5) begin
         cyc(0, 0, 0, 0, 0, 0);
         chk("bp_valid", inst_valid, 1); chk("bp_inst", inst_out, 32'h11111111);
         chk("bp_ipc", inst_pc, 32'h4); chk("bp_noreq", imem_req, 0); chk("bp_nowe", pc_we, 0);
      end
      cyc(0, 0, 0, 0, 0, 1);
      chk("bp_release", inst_valid, 1);
      // grant stall at pc 8
      repeat (3) begin
         cyc(0, 0, 0, 0, 0, 1);
         chk("gs_req", imem_req, 1); chk("gs_addr", imem_addr, 32'h8); chk("gs_busy", busy, 0);
      end
      cyc(1, 0, 0, 0, 0, 1);
      chk("gs_grant_req", imem_req, 1);
      // redirect during WAIT, response then dropped
      cyc(0, 0, 0, 1, 32'h103, 1);
      chk("rw_we", pc_we, 1); chk("rw_wd", pc_wd, 32'h100); chk("rw_busy", busy, 1);
      cyc(0, 1, 32'hDEADBEEF, 0, 0, 1);
      chk("rw_kill_we", pc_we, 0); chk("rw_kill_busy", busy, 1);
      cyc(1, 0, 0, 0, 0, 1);
      chk("rw_valid", inst_valid, 0); chk("rw_req", imem_req, 1); chk("rw_addr", imem_addr, 32'h100);
      // redirect together with response
      cyc(0, 1, 32'h44444444, 1, 32'h40, 1);
      chk("sim_we", pc_we, 1); chk("sim_wd", pc_wd, 32'h40);
      cyc(0, 0, 0, 0, 0, 1);
      chk("sim_valid", inst_valid, 0); chk("sim_req", imem_req, 1); chk("sim_addr", imem_addr, 32'h40);
      // redirect in REQ to the top word, then wrap
      cyc(1, 0, 0, 1, 32'hFFFFFFFF, 1);
      chk("rr_req", imem_req, 0); chk("rr_we", pc_we, 1); chk("rr_wd", pc_wd, 32'hFFFFFFFC);
      cyc(1, 0, 0, 0, 0, 1);
      chk("wr_req", imem_req, 1); chk("wr_addr", imem_addr, 32'hFFFFFFFC);
      cyc(0, 1, 32'hCAFEF00D, 0, 0, 1);
      exp_q.push_back({32'hCAFEF00D, 32'hFFFFFFFC});
      chk("wr_we", pc_we, 1); chk("wr_wd", pc_wd, 32'h0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("wr_ipc", inst_pc, 32'hFFFFFFFC);
      // redirect in HOLD while decode stalls
      cyc(1, 0, 0, 0, 0, 0);
      chk("rh_addr", imem_addr, 32'h0);
      cyc(0, 1, 32'h22222222, 0, 0, 0);
      chk("rh_fetch_wd", pc_wd, 32'h4);
      cyc(0, 0, 0, 1, 32'h20, 0);
      chk("rh_valid", inst_valid, 1); chk("rh_we", pc_we, 1); chk("rh_wd", pc_wd, 32'h20);
      cyc(1, 0, 0, 0, 0, 1);
      chk("rh_drop", inst_valid, 0); chk("rh_req", imem_req, 1); chk("rh_addr2", imem_addr, 32'h20);
      // reset while WAIT, late response afterwards
      @(negedge clock);
      imem_gnt = 0;
      #1;
      chk("rs_busy_pre", busy, 1);
      reset = 1;
      #1;
      chk("rs_valid", inst_valid, 0); chk("rs_req", imem_req, 0);
      chk("rs_busy", busy, 0); chk("rs_we", pc_we, 0);
      @(negedge clock);
      reset = 0; imem_rvalid = 1; imem_rdata = 32'h33333333;
      #1;
      chk("late_idle_req", imem_req, 0); chk("late_idle_valid", inst_valid, 0);
      cyc(0, 1, 32'h33333333, 0, 0, 1);
      chk("late_req", imem_req, 1); chk("late_addr", imem_addr, 32'h0); chk("late_valid", inst_valid, 0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("late_valid2", inst_valid, 0); chk("late_busy", busy, 0);
      @(negedge clock);
      #5;
      chk("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
